hamming_secded_dec_pipe: RTL and testbench

Pipelined SEC-DED decoder for the 8-bit Hamming path: accepts 13-bit codewords (8 data, 4 Hamming check bits C1/C2/C4/C8, 1 overall parity), corrects single-bit errors, and flags double-bit errors. Sits on the receive side, downstream of the link, as the counterpart to the combinational encoder. A valid/ready handshake on both sides and saturating error counters make it usable in a streaming datapath.

---
 rtl/hamming_pkg.sv | 35 +++
 rtl/hamming_syndrome.sv | 16 +
 rtl/hamming_secded_dec_pipe.sv | 132 +++++++++++++
 tb/tb_hamming_secded_dec_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the 8-bit SEC-DED Hamming path (encoder and decoder).
package hamming_pkg;

  localparam int CW_W   = 13;
  localparam int DATA_W = 8;

  // Codeword position of data bit k (positions 1, 2, 4 and 8 hold check bits).
  localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

  typedef enum logic [1:0] {
    CLEAN,
    SBE_P0,
    SBE_POS,
    DBE
  } syn_class_e;

  function automatic syn_class_e classifySyndrome(input logic [3:0] syn, input logic parity);
    syn_class_e cls;
    cls = CLEAN;
    if (parity) begin
      if (syn == 4'd0)       cls = SBE_P0;
      else if (syn <= 4'd12) cls = SBE_POS;
      else                   cls = DBE;
    end else if (syn != 4'd0) begin
      cls = DBE;
    end
    return cls;
  endfunction

  function automatic logic [DATA_W-1:0] extractData(input logic [CW_W-1:0] cw);
    return {cw[DATA_POS[7]], cw[DATA_POS[6]], cw[DATA_POS[5]], cw[DATA_POS[4]],
            cw[DATA_POS[3]], cw[DATA_POS[2]], cw[DATA_POS[1]], cw[DATA_POS[0]]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome {S8,S4,S2,S1} and overall parity of a received codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0] cw_i,
  output logic [3:0]      syn_o,
  output logic            parity_o
);

  assign syn_o[0] = cw_i[1] ^ cw_i[3] ^ cw_i[5] ^ cw_i[7] ^ cw_i[9]  ^ cw_i[11];
  assign syn_o[1] = cw_i[2] ^ cw_i[3] ^ cw_i[6] ^ cw_i[7] ^ cw_i[10] ^ cw_i[11];
  assign syn_o[2] = cw_i[4] ^ cw_i[5] ^ cw_i[6] ^ cw_i[7] ^ cw_i[12];
  assign syn_o[3] = cw_i[8] ^ cw_i[9] ^ cw_i[10] ^ cw_i[11] ^ cw_i[12];
  assign parity_o = ^cw_i;

endmodule

// File: rtl/hamming_secded_dec_pipe.sv
// Two-stage SEC-DED decoder with valid/ready on both sides and saturating error counters.
module hamming_secded_dec_pipe
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] OUT,
  output logic              single_bit_ERROR,
  output logic              two_bit_ERROR,
  output logic [3:0]        syndrome,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  sbe_cnt,
  output logic [CNT_W-1:0]  dbe_cnt
);

  logic [3:0]        synRaw;
  logic              parRaw;

  logic              s1Valid_q;
  logic [CW_W-1:0]   s1Cw_q;
  logic [3:0]        s1Syn_q;
  logic              s1Par_q;

  logic              outValid_q;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic              sbe_q, sbe_d;
  logic              dbe_q, dbe_d;
  logic [3:0]        syn_q;

  logic [CNT_W-1:0]  sbeCnt_q, sbeCnt_d;
  logic [CNT_W-1:0]  dbeCnt_q, dbeCnt_d;

  logic              s2Adv;
  logic              s1Adv;
  logic              outFire;
  syn_class_e        synClass;
  logic [CW_W-1:0]   flipMask;

  hamming_syndrome u_syndrome (
    .cw_i     (in_cw),
    .syn_o    (synRaw),
    .parity_o (parRaw)
  );

  // No skid buffer: readiness ripples combinationally from out_ready.
  assign s2Adv    = !outValid_q || out_ready;
  assign s1Adv    = !s1Valid_q || s2Adv;
  assign in_ready = rst_n && s1Adv;
  assign outFire  = outValid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Cw_q    <= '0;
      s1Syn_q   <= '0;
      s1Par_q   <= 1'b0;
    end else if (s1Adv) begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        s1Cw_q  <= in_cw;
        s1Syn_q <= synRaw;
        s1Par_q <= parRaw;
      end
    end
  end

  always_comb begin
    synClass  = classifySyndrome(s1Syn_q, s1Par_q);
    flipMask  = '0;
    if (synClass == SBE_POS) flipMask = CW_W'(1) << s1Syn_q;
    outData_d = extractData(s1Cw_q ^ flipMask);
    sbe_d     = (synClass == SBE_P0) || (synClass == SBE_POS);
    dbe_d     = (synClass == DBE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      sbe_q      <= 1'b0;
      dbe_q      <= 1'b0;
      syn_q      <= '0;
    end else if (s2Adv) begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        outData_q <= outData_d;
        sbe_q     <= sbe_d;
        dbe_q     <= dbe_d;
        syn_q     <= s1Syn_q;
      end
    end
  end

  // Clear has priority over a coincident increment.
  always_comb begin
    sbeCnt_d = sbeCnt_q;
    dbeCnt_d = dbeCnt_q;
    if (clr_cnt) begin
      sbeCnt_d = '0;
      dbeCnt_d = '0;
    end else if (outFire) begin
      if (sbe_q && (sbeCnt_q != '1)) sbeCnt_d = sbeCnt_q + CNT_W'(1);
      if (dbe_q && (dbeCnt_q != '1)) dbeCnt_d = dbeCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbeCnt_q <= '0;
      dbeCnt_q <= '0;
    end else begin
      sbeCnt_q <= sbeCnt_d;
      dbeCnt_q <= dbeCnt_d;
    end
  end

  assign out_valid        = outValid_q;
  assign OUT              = outData_q;
  assign single_bit_ERROR = sbe_q;
  assign two_bit_ERROR    = dbe_q;
  assign syndrome         = syn_q;
  assign sbe_cnt          = sbeCnt_q;
  assign dbe_cnt          = dbeCnt_q;

endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// Directed bench for hamming_secded_dec_pipe, built with 2-bit counters to reach saturation quickly.
module tb_hamming_secded_dec_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_cw;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  OUT;
  logic        single_bit_ERROR;
  logic        two_bit_ERROR;
  logic [3:0]  syndrome;
  logic        clr_cnt;
  logic [1:0]  sbe_cnt;
  logic [1:0]  dbe_cnt;

  int assertCount = 0;
  int failCount   = 0;

  hamming_secded_dec_pipe #(.CNT_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_cw            (in_cw),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .OUT              (OUT),
    .single_bit_ERROR (single_bit_ERROR),
    .two_bit_ERROR    (two_bit_ERROR),
    .syndrome         (syndrome),
    .clr_cnt          (clr_cnt),
    .sbe_cnt          (sbe_cnt),
    .dbe_cnt          (dbe_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [12:0] cw);
    in_valid = 1'b1;
    in_cw    = cw;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic checkResult(input string tag, input logic [7:0] expOut, input logic [3:0] expSyn,
                             input logic expSbe, input logic expDbe);
    checkOutput({tag, "_valid"},  16'(out_valid),        16'd1);
    checkOutput({tag, "_out"},    16'(OUT),              16'(expOut));
    checkOutput({tag, "_syn"},    16'(syndrome),         16'(expSyn));
    checkOutput({tag, "_sbe"},    16'(single_bit_ERROR), 16'(expSbe));
    checkOutput({tag, "_dbe"},    16'(two_bit_ERROR),    16'(expDbe));
  endtask

  task automatic stepAndCheckCounts(input string tag, input logic [1:0] expSbeCnt, input logic [1:0] expDbeCnt);
    @(posedge clk); #1;
    checkOutput({tag, "_sbe_cnt"}, 16'(sbe_cnt), 16'(expSbeCnt));
    checkOutput({tag, "_dbe_cnt"}, 16'(dbe_cnt), 16'(expDbeCnt));
  endtask

  logic [12:0] bpCw  [5] = '{13'h1D47, 13'h1D07, 13'h1D46, 13'h1D6F, 13'h0000};
  logic [7:0]  bpOut [5] = '{8'hE4, 8'hE4, 8'hE4, 8'hE7, 8'h00};
  logic [3:0]  bpSyn [5] = '{4'd0, 4'd6, 4'd0, 4'd6, 4'd0};
  logic        bpSbe [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        bpDbe [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int  sent;
    int  recv;
    logic accepted;
    logic fired;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cw     = '0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_in_ready",  16'(in_ready),  16'd0);
    checkOutput("rst_out",       16'(OUT),       16'd0);
    checkOutput("rst_flags",     16'({single_bit_ERROR, two_bit_ERROR}), 16'd0);
    checkOutput("rst_syn",       16'(syndrome),  16'd0);
    checkOutput("rst_cnts",      16'({sbe_cnt, dbe_cnt}), 16'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 16'(in_ready), 16'd1);

    $display("[TB] single codewords and counter saturation");
    applyStimulus(13'h1D47);
    checkResult("clean", 8'hE4, 4'd0, 1'b0, 1'b0);
    stepAndCheckCounts("clean", 2'd0, 2'd0);
    checkOutput("clean_drained", 16'(out_valid), 16'd0);

    applyStimulus(13'h1D07);
    checkResult("sbe_pos6", 8'hE4, 4'd6, 1'b1, 1'b0);
    stepAndCheckCounts("sbe_pos6", 2'd1, 2'd0);

    applyStimulus(13'h1D46);
    checkResult("sbe_p0", 8'hE4, 4'd0, 1'b1, 1'b0);
    stepAndCheckCounts("sbe_p0", 2'd2, 2'd0);

    applyStimulus(13'h1D6F);
    checkResult("dbe_3_5", 8'hE7, 4'd6, 1'b0, 1'b1);
    stepAndCheckCounts("dbe_3_5", 2'd2, 2'd1);

    applyStimulus(13'h1000);
    checkResult("sbe_pos12", 8'h00, 4'd12, 1'b1, 1'b0);
    stepAndCheckCounts("sbe_pos12", 2'd3, 2'd1);

    applyStimulus(13'h0112);
    checkResult("dbe_syn13", 8'h00, 4'd13, 1'b0, 1'b1);
    stepAndCheckCounts("dbe_syn13", 2'd3, 2'd2);

    applyStimulus(13'h0002);
    checkResult("sbe_pos1", 8'h00, 4'd1, 1'b1, 1'b0);
    stepAndCheckCounts("sbe_sat", 2'd3, 2'd2);

    $display("[TB] clear coincident with increment");
    applyStimulus(13'h1D07);
    clr_cnt = 1'b1;
    stepAndCheckCounts("clr_win", 2'd0, 2'd0);
    clr_cnt = 1'b0;

    $display("[TB] backpressure stream");
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (sent < 5);
      in_cw     = (sent < 5) ? bpCw[sent] : 13'h0;
      #1;
      accepted = in_valid && in_ready;
      fired    = out_valid && out_ready;
      if (cyc == 2 || cyc == 3) begin
        checkOutput("bp_in_ready_full", 16'(in_ready),  16'd0);
        checkOutput("bp_valid_held",    16'(out_valid), 16'd1);
      end
      if (out_valid) begin
        checkOutput("bp_out", 16'(OUT),              16'(bpOut[recv]));
        checkOutput("bp_syn", 16'(syndrome),         16'(bpSyn[recv]));
        checkOutput("bp_sbe", 16'(single_bit_ERROR), 16'(bpSbe[recv]));
        checkOutput("bp_dbe", 16'(two_bit_ERROR),    16'(bpDbe[recv]));
      end
      @(posedge clk); #1;
      if (accepted) sent++;
      if (fired)    recv++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_all_sent",     16'(sent),    16'd5);
    checkOutput("bp_all_received", 16'(recv),    16'd5);
    checkOutput("bp_sbe_cnt",      16'(sbe_cnt), 16'd2);
    checkOutput("bp_dbe_cnt",      16'(dbe_cnt), 16'd1);

    $display("[TB] asynchronous reset mid-stream");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_cw     = 13'h1D07;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_rst_pre_valid", 16'(out_valid), 16'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 16'(out_valid),        16'd0);
    checkOutput("mid_rst_out",   16'(OUT),              16'd0);
    checkOutput("mid_rst_sbe",   16'(single_bit_ERROR), 16'd0);
    checkOutput("mid_rst_syn",   16'(syndrome),         16'd0);
    checkOutput("mid_rst_cnts",  16'({sbe_cnt, dbe_cnt}), 16'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("after_rst_valid", 16'(out_valid), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
